// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter with valid/ready load port.
// Define PISO_LSB_FIRST_EN to send LSB first (default MSB first).
module piso_serializer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load_valid,
   input  logic [WIDTH-1:0] load_data,
   output logic             load_ready,
   input  logic             shift_en,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             done_q, done_d;

   logic             in_shift;
   logic             last_bit;
   logic             accept;
   logic [WIDTH-1:0] sreg_shifted;
   logic             out_bit;

   assign in_shift   = (state_q == SHIFT);
   assign last_bit   = in_shift && (cnt_q == CW'(1)) && shift_en;
   assign load_ready = (state_q == IDLE) || last_bit;
   assign accept     = load_valid && load_ready;

`ifdef PISO_LSB_FIRST_EN
   assign sreg_shifted = {1'b0, sreg_q[WIDTH-1:1]};
   assign out_bit      = sreg_q[0];
`else
   assign sreg_shifted = {sreg_q[WIDTH-2:0], 1'b0};
   assign out_bit      = sreg_q[WIDTH-1];
`endif

   always_comb begin
      state_d = state_q;
      sreg_d  = sreg_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               sreg_d  = load_data;
               cnt_d   = CW'(WIDTH);
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (shift_en) begin
               sreg_d = sreg_shifted;
               cnt_d  = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end
            end
            // a load on the last-bit edge chains the next frame
            if (accept) begin
               sreg_d  = load_data;
               cnt_d   = CW'(WIDTH);
               state_d = SHIFT;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         sreg_q  <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   assign ser_out   = in_shift & out_bit;
   assign ser_valid = in_shift;
   assign busy      = in_shift;
   assign done      = done_q;

endmodule
